// File: rtl/range_image_writer_pkg.sv
// Shared types and constants for the range-image writer and related raster blocks.
package range_image_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StEval,
    StWrite,
    StNext,
    StDone
  } state_e;

  localparam int unsigned POINT_BYTES = 8;

  // Point record field positions within the 64-bit record.
  localparam int unsigned REC_X_HI     = 63;
  localparam int unsigned REC_X_LO     = 48;
  localparam int unsigned REC_Y_HI     = 47;
  localparam int unsigned REC_Y_LO     = 40;
  localparam int unsigned REC_PAD_HI   = 39;
  localparam int unsigned REC_PAD_LO   = 32;
  localparam int unsigned REC_RANGE_HI = 31;
  localparam int unsigned REC_RANGE_LO = 16;
  localparam int unsigned REC_RSVD_HI  = 15;
  localparam int unsigned REC_RSVD_LO  = 0;

  // Index width for a counter spanning n values; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] pack_record(input logic [15:0] x, input logic [7:0] y,
                                              input logic [15:0] rng);
    logic [63:0] rec;
    rec = '0;
    rec[REC_X_HI:REC_X_LO]         = x;
    rec[REC_Y_HI:REC_Y_LO]         = y;
    rec[REC_PAD_HI:REC_PAD_LO]     = 8'h00;
    rec[REC_RANGE_HI:REC_RANGE_LO] = rng;
    rec[REC_RSVD_HI:REC_RSVD_LO]   = 16'h0000;
    return rec;
  endfunction

endpackage

// File: rtl/range_image_writer_if.sv
// Single-beat external memory write handshake: level request, done strobe.
interface range_image_writer_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic [ADDR_W-1:0] addr;
  logic [63:0]       data;
  logic              req;
  logic              done;

  modport master (output addr, output data, output req, input done);
  modport slave  (input addr, input data, input req, output done);
endinterface

// File: rtl/range_image_writer_scan.sv
// Raster-order x/y/index counter; advances one pixel per request and flags the last pixel.
module raster_scan_counter
  import range_image_pkg::*;
#(
  parameter int unsigned COLS = 2048,
  parameter int unsigned ROWS = 128,
  localparam int unsigned X_W   = idx_width(COLS),
  localparam int unsigned Y_W   = idx_width(ROWS),
  localparam int unsigned PIX_W = idx_width(COLS * ROWS)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             clear,
  input  logic             advance,
  output logic [X_W-1:0]   x,
  output logic [Y_W-1:0]   y,
  output logic [PIX_W-1:0] index,
  output logic             last
);

  localparam logic [X_W-1:0] X_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(ROWS - 1);

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Step x, wrapping into y at the end of each row; parked on the last pixel.
  always_ff @(posedge i_clk) begin
    if (i_rst || clear) begin
      x     <= '0;
      y     <= '0;
      index <= '0;
    end else if (advance && !last) begin
      index <= index + 1'b1;
      if (x == X_LAST) begin
        x <= '0;
        y <= y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/range_image_writer.sv
// Scans a COLS x ROWS range image from BRAM and writes one 64-bit point record per pixel
// to external memory, optionally dropping zero-range pixels with compacted addressing.
module range_image_writer
  import range_image_pkg::*;
#(
  parameter int unsigned COLS     = 2048,
  parameter int unsigned ROWS     = 128,
  parameter int unsigned RANGE_W  = 16,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned BRAM_LAT = 1,
  localparam int unsigned PIX_W   = idx_width(COLS * ROWS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_skip_zero,
  input  logic [ADDR_W-1:0]    i_base_addr,
  output logic [PIX_W-1:0]     o_bram_addr,
  input  logic [RANGE_W-1:0]   i_bram_data,
  range_image_writer_if.master mem,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [PIX_W:0]       o_points_written
);

  localparam int unsigned X_W      = idx_width(COLS);
  localparam int unsigned Y_W      = idx_width(ROWS);
  localparam int unsigned PT_SHIFT = $clog2(POINT_BYTES);
  localparam logic [2:0]  WAIT_INIT = 3'(BRAM_LAT - 1);

  state_e             state;
  logic [ADDR_W-1:0]  base;
  logic               skip;
  logic [2:0]         wait_cnt;
  logic [PIX_W:0]     count;
  logic [PIX_W-1:0]   bram_addr;
  logic [ADDR_W-1:0]  mem_addr;
  logic [63:0]        mem_data;
  logic               mem_req;
  logic               busy;
  logic               done;

  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [PIX_W-1:0]   index;
  logic               last;
  logic               scan_clear;
  logic               scan_advance;

  assign scan_clear   = (state == StIdle) && i_start;
  assign scan_advance = (state == StNext) && !last;

  raster_scan_counter #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_scan (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .clear   (scan_clear),
    .advance (scan_advance),
    .x       (x),
    .y       (y),
    .index   (index),
    .last    (last)
  );

  // Frame sequencer: every output is a register loaded on the state transition.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= StIdle;
      base      <= '0;
      skip      <= 1'b0;
      wait_cnt  <= '0;
      count     <= '0;
      bram_addr <= '0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_req   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done      <= 1'b0;
      // The read index is presented for a single cycle per pixel.
      bram_addr <= '0;
      unique case (state)
        StIdle: begin
          if (i_start) begin
            base  <= i_base_addr;
            skip  <= i_skip_zero;
            count <= '0;
            busy  <= 1'b1;
            state <= StIssue;
          end
        end
        StIssue: begin
          bram_addr <= index;
          wait_cnt  <= WAIT_INIT;
          state     <= StWait;
        end
        StWait: begin
          if (wait_cnt == 3'd0) begin
            state <= StEval;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end
        StEval: begin
          if (skip && (i_bram_data == '0)) begin
            state <= StNext;
          end else begin
            // Address follows the written count, so skipped pixels leave no holes.
            mem_addr <= base + (ADDR_W'(count) << PT_SHIFT);
            mem_data <= pack_record(16'(x), 8'(y), 16'(i_bram_data));
            mem_req  <= 1'b1;
            state    <= StWrite;
          end
        end
        StWrite: begin
          if (mem.done) begin
            mem_req <= 1'b0;
            count   <= count + 1'b1;
            state   <= StNext;
          end
        end
        StNext: begin
          if (last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= StDone;
          end else begin
            state <= StIssue;
          end
        end
        StDone: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

  assign o_bram_addr      = bram_addr;
  assign mem.addr         = mem_addr;
  assign mem.data         = mem_data;
  assign mem.req          = mem_req;
  assign o_busy           = busy;
  assign o_done           = done;
  assign o_points_written = count;

endmodule

// File: tb/tb_range_image_writer.sv
// Scoreboard bench: two 4x2 writers (BRAM latency 1 and 3) with pipelined BRAM models and
// a memory responder that raises done two cycles after each request.
module tb_range_image_writer;

  localparam int unsigned COLS = 4;
  localparam int unsigned ROWS = 2;
  localparam int unsigned NPIX = COLS * ROWS;

  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] data;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        skip = 1'b0;
  logic [31:0] base = 32'h0;
  logic        start0 = 1'b0;
  logic        start1 = 1'b0;
  logic        extra0 = 1'b0;

  logic [2:0]  baddr0, baddr1;
  logic [15:0] bdata0, bdata1;
  logic        busy0, busy1, done0, done1;
  logic [3:0]  pts0, pts1;

  logic [15:0] img0 [NPIX];
  logic [15:0] img1 [NPIX];
  logic [2:0]  pipe0;
  logic [2:0]  pipe1 [3];

  logic        resp0 = 1'b0;
  logic        resp1 = 1'b0;
  int          rcnt0 = 0;
  int          rcnt1 = 0;

  rec_t        exp0[$];
  rec_t        exp1[$];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt0 = 0;
  int          done_cnt1 = 0;
  int          req_cyc0 = 0;

  always #5 clk = ~clk;

  range_image_writer_if #(.ADDR_W(32)) mif0 ();
  range_image_writer_if #(.ADDR_W(32)) mif1 ();

  range_image_writer #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .RANGE_W  (16),
    .ADDR_W   (32),
    .BRAM_LAT (1)
  ) u_dut0 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start0),
    .i_skip_zero      (skip),
    .i_base_addr      (base),
    .o_bram_addr      (baddr0),
    .i_bram_data      (bdata0),
    .mem              (mif0),
    .o_busy           (busy0),
    .o_done           (done0),
    .o_points_written (pts0)
  );

  range_image_writer #(
    .COLS     (COLS),
    .ROWS     (ROWS),
    .RANGE_W  (16),
    .ADDR_W   (32),
    .BRAM_LAT (3)
  ) u_dut1 (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_start          (start1),
    .i_skip_zero      (skip),
    .i_base_addr      (base),
    .o_bram_addr      (baddr1),
    .i_bram_data      (bdata1),
    .mem              (mif1),
    .o_busy           (busy1),
    .o_done           (done1),
    .o_points_written (pts1)
  );

  // BRAM models: data is the image word for the address seen exactly LAT edges earlier.
  always @(posedge clk) begin
    pipe0    <= baddr0;
    pipe1[0] <= baddr1;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign bdata0 = img0[pipe0];
  assign bdata1 = img1[pipe1[2]];

  // Memory responders: done pulses in the third cycle of each request.
  always @(posedge clk) begin
    if (!mif0.req || resp0) begin
      rcnt0 <= 0;
      resp0 <= 1'b0;
    end else begin
      rcnt0 <= rcnt0 + 1;
      if (rcnt0 == 1) resp0 <= 1'b1;
    end
    if (!mif1.req || resp1) begin
      rcnt1 <= 0;
      resp1 <= 1'b0;
    end else begin
      rcnt1 <= rcnt1 + 1;
      if (rcnt1 == 1) resp1 <= 1'b1;
    end
  end
  assign mif0.done = resp0 | extra0;
  assign mif1.done = resp1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] rec(input logic [15:0] x, input logic [7:0] y,
                                      input logic [15:0] r);
    return {x, y, 8'h00, r, 16'h0000};
  endfunction

  task automatic push_exp(input int sel, input logic [31:0] a, input logic [63:0] d);
    rec_t e;
    e.addr = a;
    e.data = d;
    if (sel == 0) exp0.push_back(e);
    else exp1.push_back(e);
  endtask

  task automatic sb_pop(input int sel, input logic [31:0] a, input logic [63:0] d);
    rec_t e;
    int   n;
    n = (sel == 0) ? exp0.size() : exp1.size();
    if (n == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_write%0d: addr %h data %h with none pending", sel, a, d);
    end else begin
      if (sel == 0) e = exp0.pop_front();
      else e = exp1.pop_front();
      check($sformatf("wr%0d_addr", sel), 64'(a), 64'(e.addr));
      check($sformatf("wr%0d_data", sel), d, e.data);
    end
  endtask

  // Monitor: compares every completed write handshake against the scoreboard.
  always @(negedge clk) begin
    if (mif0.req === 1'b1 && mif0.done === 1'b1) sb_pop(0, mif0.addr, mif0.data);
    if (mif1.req === 1'b1 && mif1.done === 1'b1) sb_pop(1, mif1.addr, mif1.data);
    if (mif0.req === 1'b1) req_cyc0++;
    if (done0 === 1'b1) done_cnt0++;
    if (done1 === 1'b1) done_cnt1++;
  end

  // Starts a frame from a negedge and waits (bounded) for its completion pulse.
  task automatic run_frame(input int sel, input logic skip_v, input logic [31:0] base_v,
                           input int exp_pts, input string tag);
    int d_before;
    bit seen;
    seen     = 1'b0;
    d_before = (sel == 0) ? done_cnt0 : done_cnt1;
    skip     = skip_v;
    base     = base_v;
    if (sel == 0) start0 = 1'b1;
    else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    check({tag, "_busy"}, (sel == 0) ? busy0 : busy1, 1);
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (((sel == 0) ? done0 : done1) === 1'b1) seen = 1'b1;
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_at_done"}, (sel == 0) ? busy0 : busy1, 0);
    repeat (4) @(negedge clk);
    check({tag, "_done_pulses"}, ((sel == 0) ? done_cnt0 : done_cnt1) - d_before, 1);
    check({tag, "_points"}, (sel == 0) ? pts0 : pts1, 64'(exp_pts));
    check({tag, "_pending"}, (sel == 0) ? exp0.size() : exp1.size(), 0);
  endtask

  task automatic check_dut0_zero(input string tag);
    check({tag, "_busy"}, busy0, 0);
    check({tag, "_done"}, done0, 0);
    check({tag, "_req"}, mif0.req, 0);
    check({tag, "_addr"}, mif0.addr, 0);
    check({tag, "_data"}, mif0.data, 0);
    check({tag, "_pts"}, pts0, 0);
    check({tag, "_bram_addr"}, baddr0, 0);
  endtask

  initial begin
    int  r_before;
    bit  seen;
    for (int i = 0; i < NPIX; i++) begin
      img0[i] = 16'h0;
      img1[i] = 16'h0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    check_dut0_zero("rst");
    check("rst_busy1", busy1, 0);
    check("rst_pts1", pts1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Linear frame, ranges 1..8, no skipping.
    for (int i = 0; i < NPIX; i++) begin
      img0[i] = 16'(i + 1);
      push_exp(0, 32'h1000 + 32'(8 * i), rec(16'(i % COLS), 8'(i / COLS), 16'(i + 1)));
    end
    run_frame(0, 1'b0, 32'h1000, 8, "lin");

    // Skip mode, compacted output.
    img0[0] = 16'd0; img0[1] = 16'd5; img0[2] = 16'd0; img0[3] = 16'd0;
    img0[4] = 16'd7; img0[5] = 16'd0; img0[6] = 16'd0; img0[7] = 16'd9;
    push_exp(0, 32'h1000, 64'h0001_0000_0005_0000);
    push_exp(0, 32'h1008, 64'h0000_0100_0007_0000);
    push_exp(0, 32'h1010, 64'h0003_0100_0009_0000);
    run_frame(0, 1'b1, 32'h1000, 3, "skip");

    // All-zero image in skip mode: no writes at all.
    for (int i = 0; i < NPIX; i++) img0[i] = 16'h0;
    r_before = req_cyc0;
    run_frame(0, 1'b1, 32'h1000, 0, "zero");
    check("zero_req_cycles", 64'(req_cyc0 - r_before), 0);

    // Three-cycle BRAM latency.
    for (int i = 0; i < NPIX; i++) begin
      img1[i] = 16'(11 * (i + 1));
      push_exp(1, 32'h2000 + 32'(8 * i), rec(16'(i % COLS), 8'(i / COLS), 16'(11 * (i + 1))));
    end
    run_frame(1, 1'b0, 32'h2000, 8, "lat3");

    // Reset while the pixel-2 write is outstanding, then rescan from pixel 0.
    for (int i = 0; i < NPIX; i++) img0[i] = 16'(i + 1);
    push_exp(0, 32'h3000, rec(16'd0, 8'd0, 16'd1));
    push_exp(0, 32'h3008, rec(16'd1, 8'd0, 16'd2));
    skip   = 1'b0;
    base   = 32'h3000;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (mif0.req === 1'b1 && mif0.addr === 32'h3010) seen = 1'b1;
      else @(negedge clk);
    end
    check("rstmid_req_seen", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    check_dut0_zero("rstmid");
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_idle_busy", busy0, 0);
    check("rstmid_idle_req", mif0.req, 0);
    check("rstmid_pending", exp0.size(), 0);
    for (int i = 0; i < NPIX; i++)
      push_exp(0, 32'h3000 + 32'(8 * i), rec(16'(i % COLS), 8'(i / COLS), 16'(i + 1)));
    run_frame(0, 1'b0, 32'h3000, 8, "rescan");

    // Restart, mode/base changes and a stray done during EVAL must all be ignored.
    for (int i = 0; i < NPIX; i++)
      push_exp(0, 32'h1000 + 32'(8 * i), rec(16'(i % COLS), 8'(i / COLS), 16'(i + 1)));
    fork
      run_frame(0, 1'b0, 32'h1000, 8, "mid");
      begin
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
          @(negedge clk);
          if (baddr0 === 3'd3) hit = 1'b1;
        end
        check("mid_pixel3_issued", hit, 1);
        skip   = 1'b1;
        base   = 32'h9000;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        extra0 = 1'b1;
        @(negedge clk);
        extra0 = 1'b0;
      end
    join
    repeat (10) @(negedge clk);
    check("hold_points", pts0, 8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/range_image_writer.md
Name: range_image_writer

Overview:
- Parametrised successor to the single-mode range-image dump engine.
- Scans a COLS x ROWS range image held in on-chip BRAM in raster order, one pixel per BRAM read.
- Packs each pixel into a 64-bit point record and writes it to external memory through the single-beat write-transaction handshake.
- Adds a base address, configurable BRAM read latency, optional zero-range skipping with compacted output, a done pulse and a written-point count.

Parameters:
- COLS, 2048: image columns; 1..65536.
- ROWS, 128: image rows; 1..256.
- RANGE_W, 16: BRAM range-sample width; 1..16.
- ADDR_W, 32: external memory byte-address width.
- BRAM_LAT, 1: BRAM read latency in cycles (address to data); 1..4.
- PIX_W, $clog2(COLS*ROWS): derived pixel-index width; minimum 1.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_start  in  1  start pulse; accepted only in IDLE
- i_skip_zero  in  1  mode: do not write pixels whose range == 0; sampled at start
- i_base_addr  in  ADDR_W  byte address of first record; sampled at start
- o_bram_addr  out  PIX_W  BRAM read index = y*COLS + x
- i_bram_data  in  RANGE_W  BRAM read data, valid BRAM_LAT cycles after o_bram_addr
- o_mem_addr  out  ADDR_W  write byte address
- o_mem_data  out  64  point record
- o_mem_req  out  1  write request, level
- i_mem_done  in  1  write-transaction-done strobe
- o_busy  out  1  high from start accept until the DONE state
- o_done  out  1  single-cycle completion pulse
- o_points_written  out  PIX_W+1  records written in the current/last frame

Behaviour:
- Reset: i_rst is synchronous and active-high on clock i_clk.
  - All outputs are 0 during reset, including o_points_written.
  - Internal x, y and pixel index are 0.
  - State is IDLE.
  - Reset mid-transaction drops o_mem_req on the next edge with no completion wait.
- FSM states and transitions:
  - IDLE: on i_start, latch i_base_addr and i_skip_zero, clear x, y, index and count, set o_busy, go to ISSUE.
  - ISSUE: drive o_bram_addr = index for 1 cycle, then go to WAIT.
  - WAIT: hold for BRAM_LAT cycles, counted by an internal down-counter, then go to EVAL.
  - EVAL: capture i_bram_data.
    - If skip mode is on and range == 0, go to NEXT with no write.
    - Otherwise load o_mem_addr = base + 8*count, computed modulo 2^ADDR_W.
    - Load o_mem_data = {x[15:0], y[7:0], 8'h00, range zero-extended to 16, 16'h0000}.
    - Go to WRITE.
  - WRITE: o_mem_req is high from WRITE entry.
    - Address and data are held stable while o_mem_req is high.
    - On the cycle i_mem_done is sampled high: o_mem_req goes 0 on the next edge, count increments, go to NEXT.
  - NEXT:
    - If x == COLS-1 and y == ROWS-1, go to DONE.
    - Else if x == COLS-1: x = 0, y increments.
    - Else x increments.
    - Index increments in every non-DONE case; go to ISSUE.
  - DONE: o_done = 1 for exactly 1 cycle, o_busy = 0, go to IDLE.
- x and y come from counters only; no divide or modulo hardware.
- Per-pixel cost:
  - Written pixel: 3 + BRAM_LAT cycles plus the write-handshake wait.
  - Skipped pixel: 3 + BRAM_LAT cycles.
- Boundary conditions:
  - i_start while busy is ignored.
  - i_mem_done outside WRITE is ignored.
  - i_mem_done high on the WRITE entry cycle completes that write; minimum WRITE is 1 cycle.
  - Changes to i_skip_zero or i_base_addr mid-frame have no effect.
  - An all-zero image in skip mode produces zero writes, o_done pulses and the count stays 0.
  - COLS=1 or ROWS=1 must work: the first pixel can also be the last.
  - o_points_written holds its value after DONE until the next accepted start.

Decomposition:
- Shared package range_image_pkg holds:
  - FSM state localparams: IDLE, ISSUE, WAIT, EVAL, WRITE, NEXT, DONE.
  - POINT_BYTES = 8.
  - Record field offsets: X 63:48, Y 47:40, PAD 39:32, RANGE 31:16, RSVD 15:0.
- One sub-module is natural: raster_scan_counter.
  - Parameters: COLS, ROWS.
  - Ports: clear, advance; outputs x, y, index, last.
  - Reused by future read-back and projection blocks.

Test Plan:
- COLS=4, ROWS=2, BRAM_LAT=1, skip off, base 0x1000, ranges 1..8, i_mem_done asserted 2 cycles after each req:
  - 8 writes to 0x1000..0x1038 step 8.
  - Record 5 = {16'd1, 8'd1, 8'h00, 16'd6, 16'h0}.
  - o_done pulses once; count = 8.
- Same image with skip on, ranges {0,5,0,0,7,0,0,9}:
  - 3 writes at 0x1000, 0x1008, 0x1010 carrying (1,0,5), (0,1,7), (3,1,9); count = 3.
- All-zero image, skip on: o_mem_req never asserts; o_done pulses once; count = 0.
- BRAM_LAT=3 with a model returning data exactly 3 cycles after address: every record carries the correct range; a 2-cycle-latency model fails.
- i_rst pulsed while o_mem_req is high on pixel 2:
  - Next cycle all outputs are 0 and state is IDLE.
  - A new i_start rescans from pixel 0.
- i_start re-pulsed mid-frame, and i_mem_done pulsed during EVAL: no effect; frame completes with the base and mode latched at the original start.
